// File: rtl/lp_escape_rx.sv
// D-PHY LP-mode receiver: synchronizes and deglitches the Dp/Dn pair, then decodes
// stop, HS-request, escape entry, spaced-one-hot commands, LPDT bytes and ULPS.
module lp_escape_rx #(
  parameter int unsigned FILTER_CYC = 4,
  parameter int unsigned STOP_CYC   = 100,
  parameter logic [7:0]  CMD_LPDT   = 8'h87,
  parameter logic [7:0]  CMD_ULPS   = 8'h78,
  parameter logic [7:0]  CMD_TRIG   = 8'h46
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_lp_p,
  input  logic       i_lp_n,
  output logic [1:0] o_lp_state,
  output logic       o_stop,
  output logic       o_hs_req,
  output logic [7:0] o_esc_cmd,
  output logic       o_trigger,
  output logic       o_ulps,
  output logic       o_lpdt_active,
  output logic [7:0] o_data,
  output logic       o_data_valid,
  output logic       o_esc_err
);

  localparam logic [3:0] FILT_N = 4'(FILTER_CYC);
  localparam logic [9:0] STOP_N = 10'(STOP_CYC);
  localparam logic [1:0] LP11 = 2'b11;
  localparam logic [1:0] LP10 = 2'b10;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP00 = 2'b00;

  typedef enum logic [3:0] {
    S_WAIT_STOP, S_STOP, S_HS_RQ, S_ESC_RQ, S_ESC_GO, S_ESC_ACK,
    S_ESC_SPACE, S_MARK0, S_MARK1, S_ULPS, S_ULPS_EXIT
  } state_e;

  logic [1:0] sync1_q, sync1_d, sync2_q, sync2_d, vld_q, vld_d;
  logic [1:0] cand_q, cand_d, lp_q, lp_d;
  logic [3:0] flt_cnt_q, flt_cnt_d;
  logic [9:0] stop_cnt_q, stop_cnt_d;
  logic       stop_q, stop_d;
  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, esc_cmd_q, esc_cmd_d, data_q, data_d;
  logic       lpdt_q, lpdt_d, trig_q, trig_d, ulps_q, ulps_d;
  logic       hs_req_q, hs_req_d, trigger_q, trigger_d;
  logic       data_valid_q, data_valid_d, esc_err_q, esc_err_d;
  logic       f_chg, commit, commit_bit, do_exit, illegal;
  logic [7:0] byte_nxt;

  // Front end: the filter only runs once both synchronizer stages hold real samples,
  // so stale flop contents after reset can never be accepted as a line state.
  always_comb begin
    // NOTE: every _d signal gets a default before any condition so no path infers a latch.
    sync1_d   = {i_lp_p, i_lp_n};
    sync2_d   = sync1_q;
    vld_d     = {vld_q[0], 1'b1};
    cand_d    = cand_q;
    flt_cnt_d = flt_cnt_q;
    lp_d      = lp_q;
    if (vld_q[1]) begin
      if (sync2_q != cand_q) begin
        cand_d    = sync2_q;
        flt_cnt_d = 4'd1;
      end else if (flt_cnt_q != FILT_N) begin
        flt_cnt_d = flt_cnt_q + 4'd1;
      end
      if (flt_cnt_d == FILT_N) lp_d = sync2_q;
    end

    stop_cnt_d = stop_cnt_q;
    if (lp_q != LP11) stop_cnt_d = '0;
    else if (flt_cnt_q == FILT_N && stop_cnt_q != STOP_N) stop_cnt_d = stop_cnt_q + 10'd1;
    stop_d = (stop_cnt_d >= STOP_N);
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    esc_cmd_d    = esc_cmd_q;
    data_d       = data_q;
    lpdt_d       = lpdt_q;
    trig_d       = trig_q;
    ulps_d       = ulps_q;
    hs_req_d     = 1'b0;
    trigger_d    = 1'b0;
    data_valid_d = 1'b0;
    esc_err_d    = 1'b0;
    commit       = 1'b0;
    commit_bit   = 1'b0;
    do_exit      = 1'b0;
    illegal      = 1'b0;
    f_chg        = (lp_d != lp_q);

    if (state_q == S_WAIT_STOP) begin
      if (lp_d == LP11) state_d = S_STOP;
    end else if (f_chg) begin
      case (state_q)
        S_STOP: begin
          if (lp_d == LP01) state_d = S_HS_RQ;
          else if (lp_d == LP10) state_d = S_ESC_RQ;
          else illegal = 1'b1;
        end
        S_HS_RQ: begin
          if (lp_d == LP00) begin
            hs_req_d = 1'b1;
            state_d  = S_WAIT_STOP;
          end else if (lp_d == LP11) state_d = S_STOP;
          else illegal = 1'b1;
        end
        S_ESC_RQ: if (lp_d == LP00) state_d = S_ESC_GO; else illegal = 1'b1;
        S_ESC_GO: if (lp_d == LP01) state_d = S_ESC_ACK; else illegal = 1'b1;
        S_ESC_ACK: begin
          if (lp_d == LP00) begin
            state_d   = S_ESC_SPACE;
            bit_cnt_d = '0;
            shift_d   = '0;
            lpdt_d    = 1'b0;
            trig_d    = 1'b0;
          end else illegal = 1'b1;
        end
        S_ESC_SPACE: begin
          if (lp_d == LP10) state_d = S_MARK1;
          else if (lp_d == LP01) state_d = S_MARK0;
          else illegal = 1'b1;
        end
        S_MARK0: if (lp_d == LP00) commit = 1'b1; else illegal = 1'b1;
        S_MARK1: begin
          if (lp_d == LP00) begin
            commit     = 1'b1;
            commit_bit = 1'b1;
          end else if (lp_d == LP11) do_exit = 1'b1;
          else illegal = 1'b1;
        end
        S_ULPS: begin
          if (lp_d == LP10) state_d = S_ULPS_EXIT;
          else if (lp_d == LP11) begin
            state_d = S_STOP;
            ulps_d  = 1'b0;
          end else illegal = 1'b1;
        end
        S_ULPS_EXIT: begin
          if (lp_d == LP11) begin
            state_d = S_STOP;
            ulps_d  = 1'b0;
          end else if (lp_d == LP00) state_d = S_ULPS;
          else illegal = 1'b1;
        end
        default: illegal = 1'b1;
      endcase
    end

    // Bits land LSB-first: after eight shifts the first bit sits in bit 0.
    byte_nxt = {commit_bit, shift_q[7:1]};
    if (commit) begin
      shift_d   = byte_nxt;
      bit_cnt_d = bit_cnt_q + 3'd1;
      state_d   = S_ESC_SPACE;
      if (bit_cnt_q == 3'd7) begin
        if (lpdt_q) begin
          data_d       = byte_nxt;
          data_valid_d = 1'b1;
        end else if (trig_q) begin
          illegal = 1'b1;
        end else begin
          esc_cmd_d = byte_nxt;
          if (byte_nxt == CMD_LPDT) lpdt_d = 1'b1;
          else if (byte_nxt == CMD_ULPS) begin
            ulps_d  = 1'b1;
            state_d = S_ULPS;
          end else if (byte_nxt == CMD_TRIG) begin
            trigger_d = 1'b1;
            trig_d    = 1'b1;
          end else illegal = 1'b1;
        end
      end
    end

    if (do_exit) begin
      lpdt_d    = 1'b0;
      trig_d    = 1'b0;
      esc_err_d = (bit_cnt_q != 3'd0);
      state_d   = S_STOP;
    end

    if (illegal) begin
      esc_err_d = 1'b1;
      lpdt_d    = 1'b0;
      trig_d    = 1'b0;
      ulps_d    = 1'b0;
      state_d   = (lp_d == LP11) ? S_STOP : S_WAIT_STOP;
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the edge.
    if (i_reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      vld_q        <= '0;
      cand_q       <= LP11;
      flt_cnt_q    <= '0;
      lp_q         <= LP11;
      stop_cnt_q   <= '0;
      stop_q       <= 1'b0;
      state_q      <= S_WAIT_STOP;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      esc_cmd_q    <= '0;
      data_q       <= '0;
      lpdt_q       <= 1'b0;
      trig_q       <= 1'b0;
      ulps_q       <= 1'b0;
      hs_req_q     <= 1'b0;
      trigger_q    <= 1'b0;
      data_valid_q <= 1'b0;
      esc_err_q    <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      vld_q        <= vld_d;
      cand_q       <= cand_d;
      flt_cnt_q    <= flt_cnt_d;
      lp_q         <= lp_d;
      stop_cnt_q   <= stop_cnt_d;
      stop_q       <= stop_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      esc_cmd_q    <= esc_cmd_d;
      data_q       <= data_d;
      lpdt_q       <= lpdt_d;
      trig_q       <= trig_d;
      ulps_q       <= ulps_d;
      hs_req_q     <= hs_req_d;
      trigger_q    <= trigger_d;
      data_valid_q <= data_valid_d;
      esc_err_q    <= esc_err_d;
    end
  end

  assign o_lp_state    = lp_q;
  assign o_stop        = stop_q;
  assign o_hs_req      = hs_req_q;
  assign o_esc_cmd     = esc_cmd_q;
  assign o_trigger     = trigger_q;
  assign o_ulps        = ulps_q;
  assign o_lpdt_active = lpdt_q;
  assign o_data        = data_q;
  assign o_data_valid  = data_valid_q;
  assign o_esc_err     = esc_err_q;

endmodule

// File: doc/lp_escape_rx.md
Name: lp_escape_rx

Overview:
Receive-side counterpart of the D-PHY LP-state init/command generator on XO3L. Samples the asynchronous LP line pair (Dp/Dn) and decodes the low-power protocol: stop state, HS-request, escape entry, spaced-one-hot command and LPDT data bytes, ULPS and exit. Results go to the link controller as byte strobes, command flags and level indications. Runs on the 100 MHz fabric clock.

Parameters:
FILTER_CYC, 4, consecutive identical synchronized samples required before a line-state change is accepted (1..15)
STOP_CYC, 100, filtered LP-11 cycles before o_stop asserts (1..1023)
CMD_LPDT, 8'h87, LPDT entry command value (LSB-first assembled)
CMD_ULPS, 8'h78, ULPS entry command value
CMD_TRIG, 8'h46, reset-trigger command value

Ports:
i_clk  in  1  100 MHz fabric clock; all logic on its rising edge
i_reset  in  1  synchronous, active-high reset
i_lp_p  in  1  async LP receiver output, Dp
i_lp_n  in  1  async LP receiver output, Dn
o_lp_state  out  2  filtered line state {Dp,Dn}
o_stop  out  1  LP-11 held >= STOP_CYC filtered cycles
o_hs_req  out  1  1-cycle pulse: LP-11 > LP-01 > LP-00 completed
o_esc_cmd  out  8  last escape command byte, held until next command
o_trigger  out  1  1-cycle pulse: CMD_TRIG received
o_ulps  out  1  level: in ultra-low-power state
o_lpdt_active  out  1  level: in LPDT data phase
o_data  out  8  LPDT byte, valid with o_data_valid
o_data_valid  out  1  1-cycle pulse per complete LPDT byte
o_esc_err  out  1  1-cycle pulse: unknown command, partial byte at exit, or illegal sequence

Behaviour:
- Reset: all outputs 0 except o_lp_state=2'b11; FSM=WAIT_STOP; counters, shift reg, filter cleared. Reset mid-operation aborts with no pulses.
- Input path: 2-flop synchronizer per line, then filter. Counter restarts on any raw-sample change; at count FILTER_CYC the new state loads into o_lp_state. Latency raw edge to o_lp_state = 2+FILTER_CYC cycles. Glitches shorter than FILTER_CYC are ignored.
- Events below refer to changes of the filtered state (F).
- o_stop: counter increments while F=11, saturates; o_stop=1 once count>=STOP_CYC; clears the cycle after F leaves 11.
- FSM states and transitions:
  WAIT_STOP: go STOP on F=11.
  STOP: F=01 -> HS_RQ; F=10 -> ESC_RQ; F=00 -> WAIT_STOP with o_esc_err.
  HS_RQ: F=00 -> pulse o_hs_req, go WAIT_STOP; F=11 -> STOP; F=10 -> WAIT_STOP with err.
  ESC_RQ: F=00 -> ESC_GO. ESC_GO: F=01 -> ESC_ACK. ESC_ACK: F=00 -> ESC_SPACE, clear bit count and shift reg.
  ESC_SPACE: F=10 -> MARK1; F=01 -> MARK0; F=11 -> err, STOP.
  MARK0: F=00 -> shift in 0. MARK1: F=00 -> shift in 1; F=11 -> EXIT handling.
  Any other change in ESC_GO/ESC_ACK/MARK0 -> o_esc_err, then STOP if F=11, else WAIT_STOP.
- Bit commit happens on return to space, never on the mark. Bits are assembled LSB-first: the first bit goes to bit0. Bit count is 3 bits and wraps at 8.
- Byte complete (8th bit committed): if no command is latched yet, load o_esc_cmd.
  CMD_LPDT: o_lpdt_active=1; subsequent bytes output on o_data with o_data_valid in the same cycle as the 8th commit.
  CMD_ULPS: o_ulps=1, go ULPS.
  CMD_TRIG: pulse o_trigger, stay in escape awaiting exit; further bytes -> err.
  Other: o_esc_err, go WAIT_STOP.
- ULPS: stays while F=00; F=10 -> ULPS_EXIT; F=11 -> STOP with o_ulps cleared. ULPS_EXIT: F=11 -> STOP, o_ulps=0; F=00 -> ULPS.
- EXIT (mark-1 then LP-11): o_lpdt_active=0; bit count !=0 -> o_esc_err; go STOP.
- Simultaneous byte-complete and reset: reset wins. Only one filtered change is possible per cycle.

Test Plan:
- Hold 11 for 120 cycles -> o_stop rises at 2+4+100 cycles after reset release. Then 01 x10 cycles, 00 -> one o_hs_req pulse, o_stop low.
- Escape entry 11>10>00>01>00, then bits of 0x87 LSB-first (1,1,1,0,0,0,0,1) with spaces, then bytes 0xA5, 0x3C, then 10>11 -> o_esc_cmd=0x87, two o_data_valid pulses with 0xA5 then 0x3C, o_lpdt_active 1 then 0, no err.
- Escape + 0x78 -> o_ulps=1; hold 00 for 1000 cycles -> stays 1; 10>11 -> o_ulps=0, FSM STOP.
- Escape + 0x46 then exit -> single o_trigger pulse, o_esc_cmd=0x46.
- LPDT, 5 bits of a data byte, then exit -> o_esc_err pulse, no o_data_valid. Unknown command 0xFF -> o_esc_err.
- Glitch: 3-cycle 01 pulse during stop -> o_lp_state unchanged, no o_hs_req. Assert i_reset mid-LPDT -> all outputs return to reset values next cycle.
